// File: rtl/r2sdf_bf_stage.sv
// ============================================================================
// Module   : r2sdf_bf_stage
// Brief    : Radix-2 single-path delay-feedback butterfly stage feeding a CSD
//            twiddle multiplier. Optional macro: BF_FRAME_SYNC_EN (in_sof).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r2sdf_bf_stage #(
  parameter int NBITS = 12,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2*(NBITS-1)-1:0]   in_sample,
`ifdef BF_FRAME_SYNC_EN
  input  logic                     in_sof,
`endif
  output logic                     out_valid,
  output logic [2*NBITS-1:0]       out_sample,
  output logic                     out_csd,
  output logic                     out_sof
);

  localparam int              c_CW   = $clog2(2*DEPTH);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(DEPTH/2);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(2*DEPTH-1);

  logic [c_CW-1:0]        r_cnt;
  logic                   r_primed;
  logic [2*NBITS-1:0]     r_dl [DEPTH];

  logic                   w_sof_force;
  logic [c_CW-1:0]        w_cnt;
  logic                   w_primed;
  logic                   w_phase_b;
  logic                   w_out_v;
  logic                   w_csd;
  logic signed [NBITS-1:0] w_xr, w_xi, w_hr, w_hi;
  logic signed [NBITS-1:0] w_sr, w_si, w_dr, w_di;
  logic [2*NBITS-1:0]     w_wr;
  logic [2*NBITS-1:0]     w_cand;

`ifdef BF_FRAME_SYNC_EN
  assign w_sof_force = in_valid & in_sof;
`else
  assign w_sof_force = 1'b0;
`endif

  // A forced frame start behaves as sample 0 of an unprimed frame.
  assign w_cnt    = w_sof_force ? '0 : r_cnt;
  assign w_primed = r_primed & ~w_sof_force;
  assign w_phase_b = w_cnt[c_CW-1];
  assign w_out_v  = in_valid & (w_phase_b | w_primed);

  assign w_xr = {in_sample[2*(NBITS-1)-1], in_sample[2*(NBITS-1)-1:NBITS-1]};
  assign w_xi = {in_sample[NBITS-2], in_sample[NBITS-2:0]};
  assign w_hr = r_dl[DEPTH-1][2*NBITS-1:NBITS];
  assign w_hi = r_dl[DEPTH-1][NBITS-1:0];

  // One guard bit per component makes these exact.
  assign w_sr = w_hr + w_xr;
  assign w_si = w_hi + w_xi;
  assign w_dr = w_hr - w_xr;
  assign w_di = w_hi - w_xi;

  always_comb begin
    w_wr   = {w_xr, w_xi};
    w_cand = r_dl[DEPTH-1];
    w_csd  = (w_cnt < c_HALF);
    if (w_phase_b) begin
      w_wr   = {w_dr, w_di};
      w_cand = {w_sr, w_si};
      w_csd  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_dl[0] <= w_wr;
      for (int i = 1; i < DEPTH; i++) begin
        r_dl[i] <= r_dl[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_primed   <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_csd    <= 1'b1;
      out_sof    <= 1'b0;
    end else begin
      out_valid <= w_out_v;
      out_sof   <= in_valid & w_phase_b & (w_cnt[c_CW-2:0] == '0);
      if (in_valid) begin
        r_cnt <= w_cnt + 1'b1;
        if (w_cnt == c_LAST) begin
          r_primed <= 1'b1;
        end else if (w_sof_force) begin
          r_primed <= 1'b0;
        end
      end
      if (w_out_v) begin
        out_sample <= w_cand;
        out_csd    <= w_csd;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/r2sdf_bf_stage.md
Name: r2sdf_bf_stage

Overview:
- Radix-2 single-path delay-feedback (R2SDF) butterfly stage.
- Sits directly upstream of the CSD twiddle multiplier and feeds it:
  - `out_sample` drives the multiplier's packed complex `muestra`.
  - `out_csd` drives its `csd` select (1 = trivial twiddle, 0 = constant CSD coefficient).
- Takes a serial complex stream and adds one bit of growth per component, so its output width equals the multiplier's NBITS.

Parameters:
- NBITS, 12, output width per component (real/imag); input width is NBITS-1.
- DEPTH, 64, feedback delay in samples; power of two, >=2; frame length 2*DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  qualifies in_sample; state advances only when high.
- in_sample  input  2*(NBITS-1)  packed complex {real, imag}, signed two's complement.
- out_valid  output  1  qualifies out_sample/out_csd/out_sof.
- out_sample  output  2*NBITS  packed complex {real[2*NBITS-1:NBITS], imag[NBITS-1:0]}, signed.
- out_csd  output  1  twiddle select for downstream multiplier.
- out_sof  output  1  high with the first output sample of each frame.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_sample=0, out_csd=1, out_sof=0, cnt=0, primed=0.
  - Delay-line contents are not reset; primed gating makes them don't-care.
  - Reset mid-frame discards the partial frame; the first valid input after reset is frame sample 0.
- cnt: log2(2*DEPTH)-bit counter.
  - Increments on each in_valid and wraps 2*DEPTH-1 -> 0.
  - Phase A = cnt MSB 0; phase B = cnt MSB 1.
- Input sign-extended to NBITS per component before any arithmetic.
- Delay line: DEPTH entries x 2*NBITS; shifts (read head, write tail) only on in_valid.
- Phase A (cnt<DEPTH), on in_valid:
  - write x into delay line;
  - candidate output = head (difference from previous frame);
  - j = cnt.
- Phase B, on in_valid:
  - h = head (= x[n-DEPTH]);
  - candidate output = h + x per component;
  - write h - x per component.
- Arithmetic: NBITS-wide signed per component. Inputs are NBITS-1 bits, so sum and difference never overflow. No rounding or truncation.
- Output register: exactly 1-cycle latency from the accepted input to out_*.
  - out_valid = in_valid & (phase B | primed).
  - primed sets on the last phase-B sample of the first frame (cnt=2*DEPTH-1), stays set until reset.
  - When out_valid=0, out_sample and out_csd hold their previous values.
- out_csd:
  - 1 for all phase-B (sum) outputs;
  - in phase A, 0 iff j >= DEPTH/2, else 1.
- out_sof: 1 with the output produced by the first phase-B input of each frame (cnt=DEPTH).
  - Output order is sums x[k]+x[k+D] k=0..D-1, then differences; the sum block starts each output frame.
- in_valid gaps: no state change and out_valid=0 in the following cycle; arbitrary gap length is allowed.
- Simultaneous wrap and reset: reset wins.

Optional Feature:
- Macro BF_FRAME_SYNC_EN.
- Defined:
  - Adds input port in_sof (1 bit, after in_sample).
  - in_valid & in_sof forces that sample to be treated as cnt=0 (phase A, j=0); cnt becomes 1 after it.
  - primed is cleared, so the stale delay-line half is suppressed.
  - in_sof without in_valid is ignored.
- Undefined: no in_sof port; framing derives solely from the valid count since reset.

Test Plan:
- Use NBITS=12, DEPTH=4 for all scenarios.
- Impulse: frame x0=(100,-50), x1..x7=0, continuous valid.
  - Outputs 1 cycle after x4..x7: (100,-50),0,0,0 with out_sof on the first and csd=1.
  - Then, during the next frame's phase A: (100,-50),0,0,0 with csd=1,1,0,0.
- Full-scale growth: all inputs (1023,-1024).
  - Sums = (2046,-2048) with no wrap.
  - Differences = (0,0).
- Ramp: x[n]=(n,0) n=0..7.
  - Sums (4,0),(6,0),(8,0),(10,0).
  - Next-frame differences (-4,0) x4.
- Stall: same ramp with in_valid low on every other cycle.
  - Identical output values/order.
  - out_valid toggles correspondingly; 1-cycle latency per accepted sample.
- Reset mid-frame: assert rst after 5 valid inputs, release, then run the impulse test.
  - All outputs 0/csd=1 during reset.
  - Post-reset results match the impulse test exactly; no stale phase-A output before the first sum.
- (BF_FRAME_SYNC_EN) in_sof on the 3rd sample of a stream.
  - That sample becomes frame sample 0.
  - First out_sof appears 1 cycle after the 4th sample following it.
